// File: rtl/ddr_burst_initiator.sv
// Single-ID AXI-style burst initiator: issues one address phase per command, then
// streams a seeded write pattern or checks read data against it, counting errors.
module ddr_burst_initiator #(
  parameter logic [7:0] AXI_ID = 8'h00
) (
  input  logic         mem_clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [31:0]  cmd_addr,
  input  logic [7:0]   cmd_len,
  input  logic [31:0]  cmd_seed,
  output logic [7:0]   aid_0,
  output logic [31:0]  aaddr_0,
  output logic [7:0]   alen_0,
  output logic [2:0]   asize_0,
  output logic [1:0]   aburst_0,
  output logic [1:0]   alock_0,
  output logic         avalid_0,
  input  logic         aready_0,
  output logic         atype_0,
  output logic [7:0]   wid_0,
  output logic [127:0] wdata_0,
  output logic [15:0]  wstrb_0,
  output logic         wlast_0,
  output logic         wvalid_0,
  input  logic         wready_0,
  input  logic [7:0]   rid_0,
  input  logic [127:0] rdata_0,
  input  logic         rlast_0,
  input  logic         rvalid_0,
  input  logic [1:0]   rresp_0,
  output logic         rready_0,
  input  logic [7:0]   bid_0,
  input  logic         bvalid_0,
  output logic         bready_0,
  output logic         busy,
  output logic         done,
  output logic [15:0]  err_cnt
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ERR_W  = 16;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA, DONE} state_t;

  state_t              state, state_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [WORD_W-1:0]   seed_q, seed_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                err_hit;
  logic                last_beat;
  logic [WORD_W-1:0]   beat_word;
  logic [DATA_W-1:0]   beat_pat;

  assign last_beat = (beat_q == len_q);
  assign beat_word = seed_q + WORD_W'(beat_q);
  assign beat_pat  = {4{beat_word}};

  assign aid_0    = AXI_ID;
  assign wid_0    = AXI_ID;
  assign asize_0  = 3'b100;
  assign aburst_0 = 2'b01;
  assign alock_0  = 2'b00;
  assign wstrb_0  = 16'hFFFF;
  assign aaddr_0  = addr_q;
  assign alen_0   = len_q;
  assign atype_0  = wr_q;
  assign err_cnt  = err_q;

  // Next-state, command latch, beat advance and error detection
  always_comb begin
    state_d = state;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    seed_d  = seed_q;
    beat_d  = beat_q;
    err_hit = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          seed_d  = cmd_seed;
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (aready_0) state_d = wr_q ? WDATA : RDATA;
      end
      WDATA: begin
        if (wready_0) begin
          if (last_beat) state_d = WRESP;
          else           beat_d  = beat_q + LEN_W'(1);
        end
      end
      WRESP: begin
        if (bvalid_0) begin
          err_hit = (bid_0 != AXI_ID);
          state_d = DONE;
        end
      end
      RDATA: begin
        if (rvalid_0) begin
          err_hit = (rdata_0 != beat_pat) || (rresp_0 != 2'b00) ||
                    (rid_0 != AXI_ID) || (rlast_0 != last_beat);
          if (last_beat || rlast_0) state_d = DONE;
          else                      beat_d  = beat_q + LEN_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = (err_hit && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;
  end

  // State register; outputs are registered from the next-state values
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      beat_q    <= '0;
      err_q     <= '0;
      cmd_ready <= 1'b0;
      avalid_0  <= 1'b0;
      wvalid_0  <= 1'b0;
      wlast_0   <= 1'b0;
      wdata_0   <= '0;
      rready_0  <= 1'b0;
      bready_0  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      seed_q    <= seed_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      cmd_ready <= (state_d == IDLE);
      avalid_0  <= (state_d == ADDR);
      wvalid_0  <= (state_d == WDATA);
      wlast_0   <= (state_d == WDATA) && (beat_d == len_d);
      if (state_d == WDATA) wdata_0 <= {4{seed_d + WORD_W'(beat_d)}};
      rready_0  <= (state_d == RDATA);
      bready_0  <= (state_d == WRESP);
      done      <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_ddr_burst_initiator.sv
// Bench for ddr_burst_initiator: randomized responders checked against a
// pattern/error-count reference model.
module tb_ddr_burst_initiator;

  localparam logic [7:0] ID = 8'h5A;

  logic         mem_clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr, cmd_seed;
  logic [7:0]   cmd_len;
  logic [7:0]   aid_0, alen_0;
  logic [31:0]  aaddr_0;
  logic [2:0]   asize_0;
  logic [1:0]   aburst_0, alock_0;
  logic         avalid_0, aready_0, atype_0;
  logic [7:0]   wid_0;
  logic [127:0] wdata_0;
  logic [15:0]  wstrb_0;
  logic         wlast_0, wvalid_0, wready_0;
  logic [7:0]   rid_0;
  logic [127:0] rdata_0;
  logic         rlast_0, rvalid_0, rready_0;
  logic [1:0]   rresp_0;
  logic [7:0]   bid_0;
  logic         bvalid_0, bready_0;
  logic         busy, done;
  logic [15:0]  err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 mem_clk = ~mem_clk;

  ddr_burst_initiator #(.AXI_ID(ID)) dut (
    .mem_clk(mem_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .aid_0(aid_0), .aaddr_0(aaddr_0), .alen_0(alen_0), .asize_0(asize_0),
    .aburst_0(aburst_0), .alock_0(alock_0), .avalid_0(avalid_0),
    .aready_0(aready_0), .atype_0(atype_0),
    .wid_0(wid_0), .wdata_0(wdata_0), .wstrb_0(wstrb_0), .wlast_0(wlast_0),
    .wvalid_0(wvalid_0), .wready_0(wready_0),
    .rid_0(rid_0), .rdata_0(rdata_0), .rlast_0(rlast_0), .rvalid_0(rvalid_0),
    .rresp_0(rresp_0), .rready_0(rready_0),
    .bid_0(bid_0), .bvalid_0(bvalid_0), .bready_0(bready_0),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  function automatic logic [127:0] pat(input logic [31:0] s, input int k);
    logic [31:0] w;
    w = s + 32'(k);
    return {w, w, w, w};
  endfunction

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic add_err();
    if (exp_err < 65535) exp_err++;
  endtask

  // Accept a command and complete the address phase after astall refused cycles
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] seed, input int astall);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
    tick();
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_seed = $urandom;
    for (int i = 0; i <= astall; i++) begin
      aready_0 = (i == astall);
      checks++;
      if (avalid_0 !== 1'b1 || aaddr_0 !== addr || alen_0 !== len || atype_0 !== wr ||
          aid_0 !== ID || busy !== 1'b1 || cmd_ready !== 1'b0 || asize_0 !== 3'b100 ||
          aburst_0 !== 2'b01 || alock_0 !== 2'b00) begin
        errors++;
        $display("FAIL addr_phase: avalid=%b aaddr=%h alen=%h atype=%b aid=%h busy=%b rdy=%b want 1 %h %h %b %h 1 0",
                 avalid_0, aaddr_0, alen_0, atype_0, aid_0, busy, cmd_ready, addr, len, wr, ID);
      end
      tick();
    end
    aready_0 = 1'b0;
    checks++;
    if (avalid_0 !== 1'b0) begin
      errors++; $display("FAIL avalid_drop: got %b want 0", avalid_0);
    end
  endtask

  task automatic check_done();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || err_cnt !== 16'(exp_err)) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b err=%0d want 1 1 %0d", done, busy, err_cnt, exp_err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || err_cnt !== 16'(exp_err)) begin
      errors++;
      $display("FAIL after_done: done=%b rdy=%b busy=%b err=%0d want 0 1 0 %0d",
               done, cmd_ready, busy, err_cnt, exp_err);
    end
  endtask

  // mode 0: wready always, 1: 1,0,0,1 repeating, 2: random
  task automatic write_data(input logic [7:0] len, input logic [31:0] seed, input int mode,
                            input logic [7:0] bid);
    int beat = 0, cyc = 0;
    logic [127:0] held = '0;
    logic stalled = 1'b0;
    while (beat <= int'(len) && cyc < 2000) begin
      case (mode)
        0: wready_0 = 1'b1;
        1: wready_0 = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: wready_0 = 1'($urandom_range(0, 1));
      endcase
      checks++;
      if (wvalid_0 !== 1'b1 || wdata_0 !== pat(seed, beat) || wlast_0 !== (beat == int'(len)) ||
          wid_0 !== ID || wstrb_0 !== 16'hFFFF) begin
        errors++;
        $display("FAIL wbeat%0d: wvalid=%b wdata=%h wlast=%b want 1 %h %b",
                 beat, wvalid_0, wdata_0, wlast_0, pat(seed, beat), beat == int'(len));
      end
      if (stalled) begin
        checks++;
        if (wdata_0 !== held) begin
          errors++; $display("FAIL wstall_hold: wdata=%h want %h", wdata_0, held);
        end
      end
      held = wdata_0;
      stalled = !wready_0;
      tick();
      cyc++;
      if (wready_0) beat++;
    end
    wready_0 = 1'b0;
    checks++;
    if (beat != int'(len) + 1 || wvalid_0 !== 1'b0 || bready_0 !== 1'b1) begin
      errors++;
      $display("FAIL wdata_end: beats=%0d wvalid=%b bready=%b want %0d 0 1", beat, wvalid_0, bready_0, int'(len) + 1);
    end
    bvalid_0 = 1'b1; bid_0 = bid;
    tick();
    bvalid_0 = 1'b0; bid_0 = 8'($urandom);
    if (bid != ID) add_err();
    check_done();
  endtask

  // errmode injects bad resp/id/rlast; early >= 0 raises rlast on that beat instead of the last
  task automatic read_data(input logic [7:0] len, input logic [31:0] seed, input logic [31:0] dseed,
                           input int errmode, input int early);
    int beat = 0, cyc = 0;
    logic fin = 1'b0, hs;
    while (!fin && cyc < 3000) begin
      rvalid_0 = ($urandom_range(0, 3) != 0);
      rdata_0  = pat(dseed, beat);
      rresp_0  = (errmode != 0 && $urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
      rid_0    = (errmode != 0 && $urandom_range(0, 5) == 0) ? (ID ^ 8'h01) : ID;
      rlast_0  = (early >= 0) ? (beat == early) : (beat == int'(len));
      if (errmode != 0 && $urandom_range(0, 7) == 0 && beat != int'(len)) rlast_0 = 1'b1;
      checks++;
      if (rready_0 !== 1'b1) begin
        errors++; $display("FAIL rready: got %b want 1 at beat %0d", rready_0, beat);
      end
      hs = rvalid_0;
      tick();
      cyc++;
      if (hs) begin
        if (rdata_0 != pat(seed, beat) || rresp_0 != 2'b00 || rid_0 != ID ||
            rlast_0 != (beat == int'(len))) add_err();
        if (beat == int'(len) || rlast_0) fin = 1'b1;
        else beat++;
      end
    end
    rvalid_0 = 1'b0; rlast_0 = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL read_timeout: beats=%0d want %0d", beat, int'(len) + 1);
    end
    check_done();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (cmd_ready !== 1'b0 || avalid_0 !== 1'b0 || wvalid_0 !== 1'b0 || wlast_0 !== 1'b0 ||
        rready_0 !== 1'b0 || bready_0 !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        aaddr_0 !== 32'h0 || alen_0 !== 8'h0 || atype_0 !== 1'b0 || wdata_0 !== 128'h0 ||
        err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b av=%b wv=%b wl=%b rr=%b br=%b done=%b busy=%b aaddr=%h alen=%h err=%h want all 0",
               cmd_ready, avalid_0, wvalid_0, wlast_0, rready_0, bready_0, done, busy, aaddr_0, alen_0, err_cnt);
    end
    reset = 1'b0;
    exp_err = 0;
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: rdy=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    issue_cmd(1'b1, 32'h100, 8'd3, 32'h10, 0);
    write_data(8'd3, 32'h10, 0, ID);
    issue_cmd(1'b0, 32'h100, 8'd3, 32'h10, 0);
    read_data(8'd3, 32'h10, 32'h10, 0, -1);
    issue_cmd(1'b0, 32'h100, 8'd3, 32'h11, 2);
    read_data(8'd3, 32'h11, 32'h10, 0, -1);
    checks++;
    if (exp_err != 4 || err_cnt !== 16'd4) begin
      errors++; $display("FAIL mismatch_count: err=%0d want 4", err_cnt);
    end
  endtask

  task automatic test_stall();
    issue_cmd(1'b1, 32'h200, 8'd3, 32'hABCD0000, 1);
    write_data(8'd3, 32'hABCD0000, 1, ID);
    issue_cmd(1'b1, 32'h210, 8'd2, 32'h5, 0);
    write_data(8'd2, 32'h5, 0, ID ^ 8'h80);
  endtask

  task automatic test_len0_wrap();
    issue_cmd(1'b1, 32'h300, 8'd0, 32'hFFFFFFFF, 0);
    write_data(8'd0, 32'hFFFFFFFF, 0, ID);
    issue_cmd(1'b0, 32'h300, 8'd0, 32'hFFFFFFFF, 0);
    read_data(8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1);
    issue_cmd(1'b1, 32'h300, 8'd1, 32'hFFFFFFFF, 0);
    write_data(8'd1, 32'hFFFFFFFF, 2, ID);
  endtask

  task automatic test_ignore();
    int e0 = exp_err;
    for (int i = 0; i < 4; i++) begin
      rvalid_0 = 1'b1; rresp_0 = 2'b11; rid_0 = ~ID; rlast_0 = 1'b1;
      bvalid_0 = 1'b1; bid_0 = ~ID;
      tick();
      checks++;
      if (err_cnt !== 16'(e0) || busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL idle_ignore: err=%0d busy=%b done=%b want %0d 0 0", err_cnt, busy, done, e0);
      end
    end
    rvalid_0 = 1'b0; bvalid_0 = 1'b0; rlast_0 = 1'b0; rresp_0 = 2'b00;
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(1'b1, 32'h400, 8'd3, 32'h77, 0);
    wready_0 = 1'b1;
    tick(); tick();
    wready_0 = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (wvalid_0 !== 1'b0 || busy !== 1'b0 || err_cnt !== 16'h0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: wvalid=%b busy=%b err=%0d done=%b rdy=%b want 0 0 0 0 0",
               wvalid_0, busy, err_cnt, done, cmd_ready);
    end
    reset = 1'b0;
    exp_err = 0;
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || wvalid_0 !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: done=%b rdy=%b wvalid=%b want 0 1 0", done, cmd_ready, wvalid_0);
    end
    issue_cmd(1'b1, 32'h400, 8'd3, 32'h77, 0);
    write_data(8'd3, 32'h77, 0, ID);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [7:0]  len;
      logic [31:0] seed, addr, dseed;
      len   = 8'($urandom_range(0, 12));
      seed  = $urandom;
      addr  = $urandom & 32'hFFFF_FFF0;
      issue_cmd(1'b1, addr, len, seed, $urandom_range(0, 3));
      write_data(len, seed, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 8'($urandom) : ID);
      dseed = ($urandom_range(0, 2) == 0) ? seed + 32'd1 : seed;
      issue_cmd(1'b0, addr, len, seed, $urandom_range(0, 3));
      read_data(len, seed, dseed, $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : -1);
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_seed = '0;
    aready_0 = 1'b0; wready_0 = 1'b0; rid_0 = '0; rdata_0 = '0; rlast_0 = 1'b0; rvalid_0 = 1'b0;
    rresp_0 = '0; bid_0 = '0; bvalid_0 = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_len0_wrap();
    test_ignore();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_burst_initiator.md
DDR_BURST_INITIATOR -- requirements
Module: ddr_burst_initiator

Interface
REQ-001 SHALL have parameter AXI_ID, default 8'h00, the ID driven on aid_0/wid_0 and expected on rid_0/bid_0.
REQ-002 SHALL have ports, one per line:
 mem_clk  in  1  sole clock, all logic on rising edge
 reset  in  1  synchronous, active-high reset
 cmd_valid  in  1  command request
 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
 cmd_write  in  1  1=write burst, 0=read-and-check burst
 cmd_addr  in  32  byte start address, 16-byte aligned
 cmd_len  in  8  beats minus one
 cmd_seed  in  32  data pattern seed
 aid_0/aaddr_0/alen_0  out  8/32/8  address channel ID, address, length
 asize_0/aburst_0/alock_0  out  3/2/2  constant 3'b100, 2'b01 (INCR), 2'b00
 avalid_0  out  1; aready_0  in  1; atype_0  out  1 (1=write)
 wid_0  out  8; wdata_0  out  128; wstrb_0  out  16 (constant all ones)
 wlast_0  out  1; wvalid_0  out  1; wready_0  in  1
 rid_0  in  8; rdata_0  in  128; rlast_0  in  1; rvalid_0  in  1; rresp_0  in  2
 rready_0  out  1
 bid_0  in  8; bvalid_0  in  1; bready_0  out  1
 busy  out  1  not IDLE
 done  out  1  one-cycle pulse at burst completion
 err_cnt  out  16  cumulative error count, saturating

Function
REQ-003 SHALL implement FSM IDLE, ADDR, WDATA, WRESP, RDATA, DONE.
REQ-004 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&&cmd_ready, latch write/addr/len/seed, clear beat counter, go ADDR.
REQ-005 In ADDR, avalid_0=1 with aaddr_0=latched addr, alen_0=latched len, atype_0=latched write, aid_0=AXI_ID; address SHALL be stable until aready_0 sampled high.
REQ-006 avalid_0 SHALL rise the cycle after command acceptance (1-cycle latency).
REQ-007 On avalid_0&&aready_0: go WDATA if write, else RDATA; avalid_0 low next cycle.
REQ-008 Beat k (0..len) pattern SHALL be {4{seed+k}} (32-bit add, wraps modulo 2^32).
REQ-009 In WDATA, wvalid_0=1 and wdata_0=pattern(beat); beat advances only on wvalid_0&&wready_0; data held stable while wready_0=0.
REQ-010 wlast_0 SHALL be 1 exactly when beat==len while wvalid_0=1; on that handshake go WRESP.
REQ-011 In WRESP, bready_0=1; on bvalid_0 go DONE; bid_0!=AXI_ID increments err_cnt.
REQ-012 In RDATA, rready_0=1; on each rvalid_0&&rready_0 compare rdata_0 to pattern(beat), then advance beat.
REQ-013 Per read beat, err_cnt SHALL increment by one if any of: data mismatch, rresp_0!=0, rid_0!=AXI_ID, rlast_0!=(beat==len).
REQ-014 RDATA SHALL exit to DONE on handshake with beat==len or rlast_0=1, whichever first (early rlast counted per REQ-013).
REQ-015 DONE SHALL last one cycle with done=1, then IDLE; cmd_ready returns 1 the cycle after done.
REQ-016 err_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-017 len=0 SHALL give a single beat with wlast_0=1 (write) or expected rlast on beat 0 (read).
REQ-018 rvalid_0/bvalid_0 outside RDATA/WRESP SHALL be ignored and not counted.
REQ-019 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-020 While reset=1 at a mem_clk edge: state IDLE, cmd_ready=0 during reset then 1 after, avalid_0, wvalid_0, wlast_0, rready_0, bready_0, done, busy all 0; aaddr_0, alen_0, atype_0, wdata_0 0; err_cnt 0; latched command and beat counter 0.
REQ-021 Reset mid-burst SHALL abandon the burst with no done pulse; outputs at reset values the following cycle.

Verification
REQ-022 Write addr 0x100, len 3, seed 0x10 vs responder with 1-cycle aready: aaddr_0=0x100, alen_0=3, atype_0=1; wdata beats {4{0x10}}..{4{0x13}}; wlast_0 on beat 3 only; done one pulse; err_cnt 0.
REQ-023 Read same region, seed 0x10: 4 beats accepted, rlast on beat 3, err_cnt stays 0, done pulse.
REQ-024 Read with seed 0x11 (mismatch every beat): err_cnt=4 at done.
REQ-025 wready_0 toggled 1,0,0,1 during write: wdata_0 held stable across stalls, exactly len+1 handshakes.
REQ-026 len=0 write then read, seed 0xFFFFFFFF: single beat {4{0xFFFFFFFF}}, wlast_0=1, read err_cnt 0; beat-1 pattern (len=1) wraps to {4{0x00000000}}.
REQ-027 reset asserted in WDATA after 2 of 4 beats: next cycle wvalid_0=0, busy=0, err_cnt=0, no done pulse; next command starts cleanly.
